banked_sram_ctrl: RTL and testbench

BANKED_SRAM_CTRL -- requirements
Module: banked_sram_ctrl

---
 rtl/sram_pkg.sv | 30 +++
 rtl/sram_resp_fifo.sv | 74 +++++++
 rtl/banked_sram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_banked_sram_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the banked SRAM controller: controller states,
// byte-mask granularity and a width helper usable in constant expressions.
package sram_pkg;

    localparam int unsigned MASK_GRAN = 8;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        longint unsigned acc;
        res = 0;
        acc = 1;
        while (acc < value) begin
            acc = acc << 1;
            res = res + 1;
        end
        return res;
    endfunction

    // Index widths must be at least one bit even for single-entry structures.
    function automatic int unsigned max1(input int unsigned value);
        return (value == 0) ? 1 : value;
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Response queue for read data. Holds entries in arrival order; the head
// entry is presented combinationally and stays put until popped. Output
// data is forced to zero whenever the queue is empty.
module sram_resp_fifo
    import sram_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = clog2(DEPTH + 1),
    localparam int unsigned PTR_W = max1(clog2(DEPTH))
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_fire;
    logic             pop_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Handshake qualification and pointer/occupancy next-state
    always_comb begin
        pop_fire  = pop_i & (count_q != '0);
        push_fire = push_i & ((count_q != CNT_W'(DEPTH)) | pop_fire);
        wr_ptr_d  = push_fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q;
        if (push_fire && !pop_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_fire && pop_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful behind the occupancy count
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head presentation, zeroed when empty so reset clears the output data
    always_comb begin
        valid_o    = (count_q != '0);
        pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
        count_o    = count_q;
    end

endmodule

// File: rtl/banked_sram_ctrl.sv
// Banked SRAM controller: word-interleaved banks behind a single
// request/response port. After reset every row is zero-filled before
// requests are accepted. Reads return in order through a small response
// queue; an optional register stage sits between the banks and the queue.
module banked_sram_ctrl
    import sram_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 336,
    parameter  int unsigned DEPTH      = 128,
    parameter  int unsigned NUM_BANKS  = 2,
    parameter  int unsigned OUT_REG    = 0,
    localparam int unsigned ADDR_WIDTH = clog2(DEPTH),
    localparam int unsigned NUM_WMASKS = DATA_WIDTH / MASK_GRAN
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_WMASKS-1:0] req_wmask_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  init_done_o
);

    localparam int unsigned ROWS       = DEPTH / NUM_BANKS;
    localparam int unsigned ROW_W      = max1(clog2(ROWS));
    localparam int unsigned BANK_W     = max1(clog2(NUM_BANKS));
    localparam int unsigned FIFO_DEPTH = 2 + OUT_REG;
    localparam int unsigned RESP_W     = DATA_WIDTH + 1;
    localparam int unsigned CNT_W      = clog2(FIFO_DEPTH + 1);

    ctrl_state_e            state_q, state_d;
    logic [ROW_W-1:0]       init_row_q, init_row_d;

    logic [BANK_W-1:0]      bank_sel;
    logic [ROW_W-1:0]       row_sel;
    logic                   addr_in_range;
    logic                   rd_fire;
    logic                   wr_fire;
    logic [DATA_WIDTH-1:0]  bank_rdata [NUM_BANKS];
    logic [RESP_W-1:0]      rd_entry;

    logic                   push;
    logic [RESP_W-1:0]      push_data;
    logic                   inflight;
    logic                   fifo_valid;
    logic [RESP_W-1:0]      fifo_data;
    logic [CNT_W-1:0]       fifo_count;

    // Address decode: low address bits pick the bank, the rest pick the row
    always_comb begin
        addr_in_range = (32'(req_addr_i) < DEPTH);
        bank_sel      = BANK_W'(32'(req_addr_i) % NUM_BANKS);
        row_sel       = ROW_W'(32'(req_addr_i) / NUM_BANKS);
    end

    // Ready depends only on registered state, never on req_valid_i
    always_comb begin
        req_ready_o = (state_q == ST_RUN) &&
                      ((32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH);
        rd_fire     = req_valid_i & req_ready_o & ~req_we_i;
        wr_fire     = req_valid_i & req_ready_o & req_we_i;
    end

    // Zero-fill sequencing: one row of every bank per cycle, then RUN
    always_comb begin
        state_d    = state_q;
        init_row_d = init_row_q;
        if (state_q == ST_INIT) begin
            if (init_row_q == ROW_W'(ROWS - 1)) begin
                state_d    = ST_RUN;
                init_row_d = '0;
            end else begin
                init_row_d = init_row_q + ROW_W'(1);
            end
        end
    end

    // Controller state registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_INIT;
            init_row_q <= '0;
        end else begin
            state_q    <= state_d;
            init_row_q <= init_row_d;
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [ROWS];
        logic                  bank_hit;

        assign bank_hit = wr_fire & addr_in_range & (bank_sel == BANK_W'(gb));

        // Zero-fill during INIT, byte-masked write when addressed in RUN
        always_ff @(posedge clk_i) begin
            if (state_q == ST_INIT) begin
                mem[init_row_q] <= '0;
            end else if (bank_hit) begin
                for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
                    if (req_wmask_i[i]) begin
                        mem[row_sel][i*MASK_GRAN +: MASK_GRAN] <= req_wdata_i[i*MASK_GRAN +: MASK_GRAN];
                    end
                end
            end
        end

        assign bank_rdata[gb] = mem[row_sel];
    end

    // Out-of-range reads carry zero data with the error flag set
    always_comb begin
        if (addr_in_range) begin
            rd_entry = {1'b0, bank_rdata[bank_sel]};
        end else begin
            rd_entry = {1'b1, {DATA_WIDTH{1'b0}}};
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic              stage_valid_q;
        logic [RESP_W-1:0] stage_data_q;

        // Extra read-data stage; counts as in flight until it reaches the queue
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                stage_valid_q <= 1'b0;
                stage_data_q  <= '0;
            end else begin
                stage_valid_q <= rd_fire;
                if (rd_fire) begin
                    stage_data_q <= rd_entry;
                end
            end
        end

        assign push      = stage_valid_q;
        assign push_data = stage_data_q;
        assign inflight  = stage_valid_q;
    end else begin : g_no_out_reg
        assign push      = rd_fire;
        assign push_data = rd_entry;
        assign inflight  = 1'b0;
    end

    sram_resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (resp_ready_i),
        .valid_o     (fifo_valid),
        .pop_data_o  (fifo_data),
        .count_o     (fifo_count)
    );

    // Response and status outputs
    always_comb begin
        resp_valid_o = fifo_valid;
        resp_err_o   = fifo_data[DATA_WIDTH];
        resp_rdata_o = fifo_data[DATA_WIDTH-1:0];
        init_done_o  = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_banked_sram_ctrl.sv
// Bench for banked_sram_ctrl: two instances (power-of-two depth without
// output stage, non-power-of-two depth with output stage) share one request
// bus; sel routes traffic to one of them. Expected behaviour comes from a
// word-array memory model plus an ordered list of accepted reads.
module tb_banked_sram_ctrl;

    localparam int DW = 336;
    localparam int AW = 7;
    localparam int MW = 42;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [MW-1:0] req_wmask;
    logic [DW-1:0] req_wdata;
    logic          resp_ready;
    bit            sel;

    logic          v0, v1, rr0, rr1;
    logic          ready0, ready1, rvalid0, rvalid1, err0, err1, done0, done1;
    logic [DW-1:0] rdata0, rdata1;
    logic          m_ready, m_valid, m_err;
    logic [DW-1:0] m_rdata;

    always #5 clk = ~clk;

    assign v0      = req_valid & ~sel;
    assign v1      = req_valid & sel;
    assign rr0     = sel ? 1'b1 : resp_ready;
    assign rr1     = sel ? resp_ready : 1'b1;
    assign m_ready = sel ? ready1 : ready0;
    assign m_valid = sel ? rvalid1 : rvalid0;
    assign m_err   = sel ? err1 : err0;
    assign m_rdata = sel ? rdata1 : rdata0;

    banked_sram_ctrl #(.DATA_WIDTH(336), .DEPTH(128), .NUM_BANKS(2), .OUT_REG(0)) dut0 (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(v0), .req_ready_o(ready0),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wmask_i(req_wmask),
        .req_wdata_i(req_wdata), .resp_valid_o(rvalid0), .resp_ready_i(rr0),
        .resp_rdata_o(rdata0), .resp_err_o(err0), .init_done_o(done0)
    );

    banked_sram_ctrl #(.DATA_WIDTH(336), .DEPTH(100), .NUM_BANKS(4), .OUT_REG(1)) dut1 (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(v1), .req_ready_o(ready1),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wmask_i(req_wmask),
        .req_wdata_i(req_wdata), .resp_valid_o(rvalid1), .resp_ready_i(rr1),
        .resp_rdata_o(rdata1), .resp_err_o(err1), .init_done_o(done1)
    );

    typedef struct {
        int          acc;
        logic [DW:0] resp;
    } ent_t;

    ent_t          oq[$];
    logic [DW-1:0] mm [2][128];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            edges = 0;

    function automatic int depth_of(input bit s); return s ? 100 : 128; endfunction
    function automatic int rows_of(input bit s);  return s ? 25 : 64;   endfunction
    function automatic int lat_of(input bit s);   return s ? 2 : 1;     endfunction
    function automatic int fd_of(input bit s);    return s ? 3 : 2;     endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [351:0] t;
        for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    function automatic logic [MW-1:0] rnd_mask();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[MW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        oq.delete();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 128; a++) mm[s][a] = '0;
    endtask

    // One clock cycle: apply inputs, check outputs against the model, update it.
    task automatic drive(input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [MW-1:0] m, input logic [DW-1:0] d,
                         input bit rr, output bit acc);
        bit   exp_ready, exp_valid, exp_done;
        ent_t e;
        @(posedge clk);
        edges++;
        #1;
        req_valid = v; req_we = we; req_addr = a; req_wmask = m;
        req_wdata = d; resp_ready = rr;
        #1;
        chk("init_done0", done0, edges >= rows_of(1'b0));
        chk("init_done1", done1, edges >= rows_of(1'b1));
        exp_done  = edges >= rows_of(sel);
        exp_ready = exp_done && (oq.size() < fd_of(sel));
        chk("req_ready", m_ready, exp_ready);
        exp_valid = (oq.size() > 0) && ((cyc - oq[0].acc) >= lat_of(sel));
        chk("resp_valid", m_valid, exp_valid);
        if (exp_valid) chk("resp_data", {m_err, m_rdata}, oq[0].resp);
        if (exp_valid && rr) void'(oq.pop_front());
        acc = v && exp_ready;
        if (acc) begin
            if (we) begin
                if (int'(a) < depth_of(sel))
                    for (int i = 0; i < MW; i++)
                        if (m[i]) mm[sel][a][i*8 +: 8] = d[i*8 +: 8];
            end else begin
                e.acc  = cyc;
                e.resp = (int'(a) < depth_of(sel)) ? {1'b0, mm[sel][a]} : {1'b1, DW'(0)};
                oq.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit rr);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, rr, acc);
    endtask

    task automatic issue(input bit we, input logic [AW-1:0] a, input logic [MW-1:0] m,
                         input logic [DW-1:0] d, input bit rr);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin
            drive(1'b1, we, a, m, d, rr, acc);
            n++;
        end
        chk(we ? "write_accept" : "read_accept", acc, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_ready0", ready0, 1'b0);   chk("rst_ready1", ready1, 1'b0);
        chk("rst_valid0", rvalid0, 1'b0);  chk("rst_valid1", rvalid1, 1'b0);
        chk("rst_err0", err0, 1'b0);       chk("rst_err1", err1, 1'b0);
        chk("rst_rdata0", rdata0, '0);     chk("rst_rdata1", rdata1, '0);
        chk("rst_done0", done0, 1'b0);     chk("rst_done1", done1, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        rstn  = 1'b1;
        edges = 0;
    endtask

    task automatic random_phase(input int n);
        bit acc;
        for (int i = 0; i < n; i++)
            drive(($urandom % 4) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 127)),
                  rnd_mask(), rnd_data(), ($urandom % 4) != 0, acc);
    endtask

    initial begin
        rstn = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wmask = '0; req_wdata = '0; resp_ready = 1'b1; sel = 1'b0;
        model_clear();
        #2;

        // Reset, zero-fill timing for both instances, first read returns zero
        do_reset();
        idle(70, 1'b1);
        issue(1'b0, 7'd5, '0, '0, 1'b1);
        idle(1, 1'b1);
        chk("read5_valid", m_valid, 1'b1);
        chk("read5_data", {m_err, m_rdata}, '0);
        idle(2, 1'b1);

        // Full-mask write then next-cycle read, one-cycle response latency
        issue(1'b1, 7'd3, '1, {42{8'hA5}}, 1'b1);
        issue(1'b0, 7'd3, '0, '0, 1'b1);
        idle(1, 1'b1);
        chk("a5_valid", m_valid, 1'b1);
        chk("a5_data", {m_err, m_rdata}, {1'b0, {42{8'hA5}}});
        idle(2, 1'b1);

        // Single-byte mask over zero
        issue(1'b1, 7'd7, 42'h1, '1, 1'b1);
        issue(1'b0, 7'd7, '0, '0, 1'b1);
        idle(1, 1'b1);
        chk("mask_data", {m_err, m_rdata}, (DW + 1)'(8'hFF));
        idle(2, 1'b1);

        // Backpressure: queue fills, ready drops, order preserved on release
        issue(1'b1, 7'd0, '1, rnd_data(), 1'b1);
        issue(1'b1, 7'd1, '1, rnd_data(), 1'b1);
        issue(1'b1, 7'd2, '1, rnd_data(), 1'b1);
        issue(1'b0, 7'd0, '0, '0, 1'b0);
        issue(1'b0, 7'd1, '0, '0, 1'b0);
        idle(3, 1'b0);
        chk("full_ready", m_ready, 1'b0);
        issue(1'b0, 7'd2, '0, '0, 1'b1);
        idle(4, 1'b1);
        chk("drained", oq.size(), 0);

        random_phase(300);
        idle(6, 1'b1);

        // Reset with two responses pending
        issue(1'b0, 7'd10, '0, '0, 1'b0);
        issue(1'b0, 7'd11, '0, '0, 1'b0);
        idle(2, 1'b0);
        do_reset();
        idle(70, 1'b1);
        issue(1'b0, 7'd3, '0, '0, 1'b1);
        issue(1'b0, 7'd7, '0, '0, 1'b1);
        issue(1'b0, 7'd10, '0, '0, 1'b1);
        idle(4, 1'b1);

        // Non-power-of-two depth with output stage: out-of-range handling
        sel = 1'b1;
        idle(2, 1'b1);
        issue(1'b1, 7'd20, '1, rnd_data(), 1'b1);
        issue(1'b0, 7'd120, '0, '0, 1'b1);
        idle(1, 1'b1);
        idle(1, 1'b1);
        chk("oor_valid", m_valid, 1'b1);
        chk("oor_resp", {m_err, m_rdata}, {1'b1, DW'(0)});
        idle(2, 1'b1);
        issue(1'b1, 7'd120, '1, rnd_data(), 1'b1);
        issue(1'b1, 7'd20, '0, rnd_data(), 1'b1);
        issue(1'b0, 7'd20, '0, '0, 1'b1);
        idle(4, 1'b1);

        random_phase(300);
        idle(8, 1'b1);
        chk("final_drain", oq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
